// File: rtl/hdr_pkg.sv
// Shared constants and FSM encoding for the HDR triple-exposure fetch scheduler.
package hdr_pkg;

    localparam int unsigned HDR_ADDR_W      = 24;
    localparam int unsigned HDR_FRAME_WORDS = 38400;
    localparam int unsigned HDR_CREDITS     = 2;

    localparam logic [HDR_ADDR_W-1:0] HDR_BASE_HIGH   = 24'h000000;
    localparam logic [HDR_ADDR_W-1:0] HDR_BASE_MID    = 24'h010000;
    localparam logic [HDR_ADDR_W-1:0] HDR_BASE_LOW    = 24'h020000;
    localparam logic [HDR_ADDR_W-1:0] HDR_BANK_OFFSET = 24'h030000;

    typedef enum logic [2:0] {
        StIdle,
        StReqH,
        StWaitH,
        StReqM,
        StWaitM,
        StReqL,
        StWaitL,
        StPush
    } fetch_state_e;

endpackage

// File: rtl/hdr_credit_counter.sv
// Saturating credit counter tracking free triple slots in the downstream pixel buffer.
module hdr_credit_counter #(
    parameter int unsigned CREDITS = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic nonzero
);

    localparam int unsigned CNT_W = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

    logic [CNT_W-1:0] count_q, count_d;

    // Simultaneous inc and dec cancel; both directions saturate.
    always_comb begin
        count_d = count_q;
        if (dec && !inc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end else if (inc && !dec && count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CNT_MAX;
        end else begin
            count_q <= count_d;
        end
    end

    assign nonzero = (count_q != '0);

endmodule

// File: rtl/hdr_fetch_scheduler.sv
// Fetches one high/mid/low SDRAM word triple per pixel slot and pushes it downstream on credit.
// Optional bank ping-pong selected by defining FRAME_PINGPONG_EN.
module hdr_fetch_scheduler
    import hdr_pkg::*;
#(
    parameter int unsigned          ADDR_W      = HDR_ADDR_W,
    parameter int unsigned          FRAME_WORDS = HDR_FRAME_WORDS,
    parameter logic [ADDR_W-1:0]    BASE_HIGH   = HDR_BASE_HIGH,
    parameter logic [ADDR_W-1:0]    BASE_MID    = HDR_BASE_MID,
    parameter logic [ADDR_W-1:0]    BASE_LOW    = HDR_BASE_LOW,
    parameter logic [ADDR_W-1:0]    BANK_OFFSET = HDR_BANK_OFFSET,
    parameter int unsigned          CREDITS     = HDR_CREDITS
) (
    input  logic              clk_133M,
    input  logic              rst_n_133M,
    input  logic              frame_start,
    input  logic              slot_free,
    input  logic              wr_bank,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic [127:0]      mem_rd_data,
    input  logic              mem_rd_data_valid,
    output logic [127:0]      data_high,
    output logic [127:0]      data_mid,
    output logic [127:0]      data_low,
    output logic              rd_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned PTR_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FRAME_WORDS - 1);

    // Each exposure window must end before the next one (and before the second bank) starts.
    if ((int'(BASE_HIGH) + int'(FRAME_WORDS) > int'(BASE_MID)) ||
        (int'(BASE_MID) + int'(FRAME_WORDS) > int'(BASE_LOW)) ||
        (int'(BASE_LOW) + int'(FRAME_WORDS) > int'(BANK_OFFSET))) begin : g_bad_layout
        $error("hdr_fetch_scheduler: exposure frames overlap or cross into the second bank");
    end

    fetch_state_e      state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              armed_q, armed_d;
    logic              start_pend_q, start_pend_d;
    logic              cap_high, cap_mid, cap_low;
    logic              push;
    logic              credit_ok;
    logic              apply_start;
    logic [ADDR_W-1:0] base_sel;
    logic [ADDR_W-1:0] bank_off;

    hdr_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credits (
        .clk     (clk_133M),
        .rst_n   (rst_n_133M),
        .inc     (slot_free),
        .dec     (push),
        .nonzero (credit_ok)
    );

`ifdef FRAME_PINGPONG_EN
    logic bank_q;

    // Read the bank capture is not writing; held for the whole frame.
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            bank_q <= 1'b0;
        end else if (apply_start) begin
            bank_q <= ~wr_bank;
        end
    end

    assign bank_off = bank_q ? BANK_OFFSET : '0;
`else
    logic unused_wr_bank;

    assign unused_wr_bank = wr_bank;
    assign bank_off       = '0;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        armed_d      = armed_q;
        start_pend_d = start_pend_q | frame_start;
        apply_start  = 1'b0;
        mem_rd_req   = 1'b0;
        cap_high     = 1'b0;
        cap_mid      = 1'b0;
        cap_low      = 1'b0;
        push         = 1'b0;
        frame_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_pend_q) begin
                    apply_start  = 1'b1;
                    ptr_d        = '0;
                    armed_d      = 1'b1;
                    start_pend_d = 1'b0;
                end else if (armed_q && credit_ok) begin
                    state_d = StReqH;
                end
            end
            StReqH: begin
                mem_rd_req = 1'b1;
                if (mem_rd_gnt) state_d = StWaitH;
            end
            StWaitH: begin
                if (mem_rd_data_valid) begin
                    cap_high = 1'b1;
                    state_d  = StReqM;
                end
            end
            StReqM: begin
                mem_rd_req = 1'b1;
                if (mem_rd_gnt) state_d = StWaitM;
            end
            StWaitM: begin
                if (mem_rd_data_valid) begin
                    cap_mid = 1'b1;
                    state_d = StReqL;
                end
            end
            StReqL: begin
                mem_rd_req = 1'b1;
                if (mem_rd_gnt) state_d = StWaitL;
            end
            StWaitL: begin
                if (mem_rd_data_valid) begin
                    cap_low = 1'b1;
                    state_d = StPush;
                end
            end
            StPush: begin
                push    = 1'b1;
                state_d = StIdle;
                if (ptr_q == PTR_LAST) begin
                    ptr_d      = '0;
                    armed_d    = 1'b0;
                    frame_done = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        base_sel = BASE_HIGH;
        if (state_q == StReqM) base_sel = BASE_MID;
        if (state_q == StReqL) base_sel = BASE_LOW;
    end

    // Address is only meaningful while requesting; kept at zero otherwise.
    assign mem_rd_addr = mem_rd_req ? (base_sel + bank_off + ADDR_W'(ptr_q)) : '0;
    assign rd_valid    = push;
    assign busy        = (state_q != StIdle);

    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            armed_q      <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            armed_q      <= armed_d;
            start_pend_q <= start_pend_d;
        end
    end

    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            data_high <= '0;
            data_mid  <= '0;
            data_low  <= '0;
        end else begin
            if (cap_high) data_high <= mem_rd_data;
            if (cap_mid)  data_mid  <= mem_rd_data;
            if (cap_low)  data_low  <= mem_rd_data;
        end
    end

endmodule
